// File: rtl/h2f_led_sequencer.sv
// LED blink sequencer driven by the IPC dispatcher.
// A START strobe with a non-zero BLINKS value begins BLINKS on/off cycles.
// Each cycle is ON_CYCLES lit followed by OFF_CYCLES dark. While a sequence
// is running, further START strobes are ignored.
module h2f_led_sequencer #(
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned OFF_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       START,
  input  logic [7:0] BLINKS,
  output logic       IDLE,
  output logic       LED
);

  // The phase counter counts down from (length - 1) to 0. It therefore only
  // needs to hold values up to max(ON, OFF) - 1, and it never wraps.
  localparam int unsigned MaxCycles = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned PhaseW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [PhaseW-1:0] OnLoad  = PhaseW'(ON_CYCLES - 1);
  localparam logic [PhaseW-1:0] OffLoad = PhaseW'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_e;

  state_e            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [7:0]        remain_q, remain_d;
  logic              led_q;

  // Next-state logic for the FSM, the phase counter and the blink counter.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    unique case (state_q)
      S_IDLE: begin
        // When BLINKS is zero the block accepts the request but does nothing.
        if (START && (BLINKS != 8'd0)) begin
          remain_d = BLINKS;
          phase_d  = OnLoad;
          state_d  = S_ON;
        end
      end
      S_ON: begin
        if (phase_q == '0) begin
          phase_d = OffLoad;
          state_d = S_OFF;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      S_OFF: begin
        if (phase_q == '0) begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = S_IDLE;
          end else begin
            phase_d = OnLoad;
            state_d = S_ON;
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. The synchronous reset takes priority over START.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      remain_q <= '0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      // LED is registered from the next state, so it is high exactly while
      // the FSM is in S_ON.
      led_q    <= (state_d == S_ON);
    end
  end

  assign LED  = led_q;
  assign IDLE = (state_q == S_IDLE) && !START;

endmodule
